// File: rtl/spi_result_transmitter.sv
// ============================================================================
// Module   : spi_result_transmitter
// Purpose  : SPI-peripheral transmitter that returns result words to the MCU;
//            spiClk/ncs are oversampled in the mainClk domain.
// Options  : define SPI_TX_PARITY_EN to append an even-parity bit per frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_result_transmitter #(
    parameter int                     messageBits = 8,
    parameter int                     fifoDepth   = 4,
    parameter logic [messageBits-1:0] IDLE_WORD   = '0
) (
    input  logic                               mainClk,
    input  logic                               nreset,
    input  logic                               spiClk,
    input  logic                               ncs,
    output logic                               sdo,
    input  logic [messageBits-1:0]             txData,
    input  logic                               txValid,
    output logic                               txReady,
    output logic [$clog2(fifoDepth+1)-1:0]     fifoCount,
    output logic                               frameDone,
    output logic                               underflow
);

`ifdef SPI_TX_PARITY_EN
    localparam int c_FRAME_LEN = messageBits + 1;
`else
    localparam int c_FRAME_LEN = messageBits;
`endif
    localparam int c_CNT_W  = $clog2(c_FRAME_LEN + 1);
    localparam int c_PTR_W  = $clog2(fifoDepth);
    localparam int c_FCNT_W = $clog2(fifoDepth + 1);
    localparam logic [c_CNT_W-1:0]  c_FRAME_CNT = c_CNT_W'(c_FRAME_LEN);
    localparam logic [c_FCNT_W-1:0] c_FULL      = c_FCNT_W'(fifoDepth);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        LOAD      = 2'd2,
        SHIFT     = 2'd3
    } state_t;

    logic                   r_sclkS1, r_sclkS2, r_sclkH;
    logic                   r_csS1, r_csS2, r_csH;
    logic                   r_rstDone;
    logic                   w_sclkFall, w_csFall, w_csRise;

    logic [messageBits-1:0] r_mem [fifoDepth];
    logic [c_PTR_W-1:0]     r_wrPtr, r_rdPtr;
    logic [c_FCNT_W-1:0]    r_count;
    logic                   w_push, w_pop, w_empty;

    state_t                 r_state, w_stateNext;
    logic                   w_load, w_shift, w_frameDoneNext, w_underflowNext;
    logic [messageBits-1:0] w_word;
    logic [c_FRAME_LEN-1:0] w_loadWord;
    logic [c_FRAME_LEN-1:0] r_shift;
    logic [c_CNT_W-1:0]     r_bitCount;
    logic                   r_sdo, r_frameDone, r_underflow;

    always_ff @(posedge mainClk) begin
        if (!nreset) begin
            {r_sclkS1, r_sclkS2, r_sclkH} <= 3'b000;
            {r_csS1, r_csS2, r_csH}       <= 3'b111;
            r_rstDone                     <= 1'b0;
        end else begin
            {r_sclkS1, r_sclkS2, r_sclkH} <= {spiClk, r_sclkS1, r_sclkS2};
            {r_csS1, r_csS2, r_csH}       <= {ncs, r_csS1, r_csS2};
            r_rstDone                     <= 1'b1;
        end
    end

    assign w_sclkFall = r_sclkH & ~r_sclkS2;
    assign w_csFall   = r_csH & ~r_csS2;
    assign w_csRise   = ~r_csH & r_csS2;

    assign w_empty   = (r_count == '0);
    assign txReady   = nreset && (r_count != c_FULL);
    assign w_push    = txValid && txReady;
    assign fifoCount = r_count;

    always_ff @(posedge mainClk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= txData;
        end
    end

    always_ff @(posedge mainClk) begin
        if (!nreset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_FCNT_W'(1);
                2'b01:   r_count <= r_count - c_FCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_word = w_empty ? IDLE_WORD : r_mem[r_rdPtr];
`ifdef SPI_TX_PARITY_EN
    assign w_loadWord = {w_word, ^w_word};
`else
    assign w_loadWord = w_word;
`endif

    always_ff @(posedge mainClk) begin
        if (!nreset) r_state <= WAIT_IDLE;
        else         r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext     = r_state;
        w_pop           = 1'b0;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        w_frameDoneNext = 1'b0;
        w_underflowNext = 1'b0;
        case (r_state)
            // The synchronizer still holds its reset value on the first
            // cycle after reset, so wait for it to reflect the real pin.
            WAIT_IDLE: if (r_rstDone && r_csS1 && r_csS2) w_stateNext = IDLE;
            IDLE:      if (w_csFall) w_stateNext = LOAD;
            LOAD: begin
                w_load          = 1'b1;
                w_pop           = !w_empty;
                w_underflowNext = w_empty;
                w_stateNext     = w_csRise ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (w_csRise) begin
                    w_stateNext     = IDLE;
                    w_frameDoneNext = (r_bitCount == c_FRAME_CNT);
                end else begin
                    w_shift = w_sclkFall;
                end
            end
            default: w_stateNext = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge mainClk) begin
        if (!nreset) begin
            r_shift     <= '0;
            r_bitCount  <= '0;
            r_sdo       <= 1'b0;
            r_frameDone <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift    <= w_loadWord;
                r_bitCount <= '0;
            end else if (w_shift) begin
                r_shift <= {r_shift[c_FRAME_LEN-2:0], 1'b0};
                if (r_bitCount != c_FRAME_CNT) r_bitCount <= r_bitCount + c_CNT_W'(1);
            end
            r_sdo       <= (r_state == SHIFT) ? r_shift[c_FRAME_LEN-1] : 1'b0;
            r_frameDone <= w_frameDoneNext;
            r_underflow <= w_underflowNext;
        end
    end

    assign sdo       = r_sdo;
    assign frameDone = r_frameDone;
    assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: doc/spi_result_transmitter.md
# spi_result_transmitter

Returns processed edge-detection results from the FPGA to the MCU over SPI, with the FPGA acting as SPI peripheral. Result words arrive on a valid/ready interface, are buffered in a small FIFO, and are shifted out MSB-first on `sdo` for each MCU chip-select frame. The raw `spiClk` and `ncs` pins are oversampled in the `mainClk` domain, so the block needs only one clock. It is the transmit counterpart to the existing SPI pixel-receive path and shares the same `spiClk`/`ncs` pins.

## Interface
Parameters:
- `messageBits`, 8: data bits per frame.
- `fifoDepth`, 4: result FIFO entries; must be a power of two, ≥2.
- `IDLE_WORD`, 0: word shifted out when the FIFO is empty at frame start.

Ports:
- `mainClk` in 1: sole clock.
- `nreset` in 1: synchronous, active-low reset.
- `spiClk` in 1: raw SPI clock from the MCU, asynchronous; mode 0.
- `ncs` in 1: raw active-low chip select, asynchronous.
- `sdo` out 1: serial data to the MCU.
- `txData` in `messageBits`: result word to enqueue.
- `txValid` in 1: `txData` is valid.
- `txReady` out 1: FIFO can accept a word.
- `fifoCount` out `$clog2(fifoDepth+1)`: current FIFO occupancy.
- `frameDone` out 1: one-cycle pulse when a frame completes with all bits clocked.
- `underflow` out 1: one-cycle pulse when a frame starts with the FIFO empty.

## Operation
- **Synchronizers:** `spiClk` and `ncs` each pass through a 2-flop synchronizer plus one history flop.
  - Reset values: `spiClk` chain 0, `ncs` chain 1.
  - Edge detect: `sclkFall` = history 1 and synced 0. `csFall` and `csRise` are derived the same way.
- **FIFO:**
  - Push when `txValid && txReady`.
  - `txReady = (fifoCount != fifoDepth)`; forced 0 while `nreset` is low.
  - Pop happens only in LOAD. There is no write-to-read bypass.
  - A push and a pop in the same cycle leave `fifoCount` unchanged.
- **FSM states:** WAIT_IDLE, IDLE, LOAD, SHIFT.
  - WAIT_IDLE (reset state): go to IDLE once synced `ncs` == 1. This prevents joining a frame that is already in progress.
  - IDLE: `csFall` → LOAD.
  - LOAD (one cycle):
    - FIFO non-empty: pop the head into the shift register.
    - FIFO empty: load `IDLE_WORD` and pulse `underflow`.
    - Clear `bitCount`, then go to SHIFT.
  - SHIFT:
    - `sdo` = shift register MSB.
    - Each `sclkFall`: shift left with zero fill, `bitCount++`. `bitCount` saturates at the frame length.
    - `csRise`: go to IDLE. Pulse `frameDone` only if `bitCount` == frame length.
- **Early abort:** if `ncs` rises early, the popped word is discarded. It is not re-queued and `frameDone` does not pulse.
- **Extra clocks:** `spiClk` falling edges beyond the frame length shift out 0s.
- **`sdo` outside SHIFT:** 0.
- **`sclkFall` and `csRise` in the same cycle:** `csRise` wins; the shift is ignored.

## Timing
- Reset values: `sdo` 0, `txReady` 0, `fifoCount` 0, `frameDone` 0, `underflow` 0. FIFO is empty, FSM is in WAIT_IDLE.
- A reset mid-frame flushes the FIFO and returns the FSM to WAIT_IDLE.
- `csFall` is seen 3 cycles after a raw `ncs` fall. LOAD follows, and the MSB appears on `sdo` 5 cycles after the raw fall.
- The MCU must meet two limits, both measured in `mainClk` periods:
  - `ncs` fall to first `spiClk` rise: ≥ 6.
  - `spiClk` high and low phases: each ≥ 4.
- Bit n+1 appears on `sdo` 4 cycles after the raw `spiClk` fall. This is before the next rise given the phase rule above.
- `frameDone` and `underflow` are registered single-cycle pulses.
- `txReady` deasserts in the cycle after the push that fills the FIFO.

## Configuration
- `SPI_TX_PARITY_EN` defined:
  - Frame length is `messageBits+1`.
  - An even-parity bit over the loaded word is appended after the LSB.
  - `frameDone` requires all `messageBits+1` bits to be clocked.
- Undefined: frame length is `messageBits`; no parity logic.

## Test plan
- **Single word:** push 0xA5, run one 8-clock frame → MCU samples 1,0,1,0,0,1,0,1. `fifoCount` goes 1→0 in LOAD. `frameDone` pulses once after `ncs` rises.
- **Backpressure:**
  - Push 0x01–0x04 → `txReady` goes 0. A held push of 0xFF is not accepted.
  - After one frame returns 0x01, `txReady` goes 1 and 0xFF is accepted. The following frames return 0x02, 0x03, 0x04, 0xFF.
- **Empty FIFO:** frame with an empty FIFO → 0x00 shifted out, `underflow` pulses for 1 cycle, `fifoCount` stays 0, `frameDone` still pulses.
- **Early abort:** push 0x3C and 0x55. Raise `ncs` after 3 clocks → MCU reads 0,0,1 and `frameDone` does not pulse. The next frame returns 0x55.
- **Reset with `ncs` low:** release reset while `ncs` is held low and clock 8 bits → no pop, `sdo` stays 0. After `ncs` goes high then low, the frame proceeds normally.
- **Parity:** with `SPI_TX_PARITY_EN`, push 0x07 and run 9 clocks → 0,0,0,0,0,1,1,1,1, and `frameDone` pulses. A frame stopped after 8 clocks gives no `frameDone`.
